// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: one CHUNK-bit ripple digit per cycle, carry registered between
// digits. Define DIGIT_SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module digit_serial_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  ,output logic             ovf
`endif
);

   localparam int unsigned NDIG = WIDTH / CHUNK;
   localparam int unsigned DW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [WIDTH-1:0] DigMask = WIDTH'({CHUNK{1'b1}});

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic             carry_q, carry_d, cout_q, cout_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic [DW-1:0]    dig_q, dig_d;

   logic [CHUNK-1:0] a_dig, b_dig, s_dig;
   logic             chain_c;
   int unsigned      base;

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
   logic ovf_q, ovf_d;
   logic c_msb;
`endif

   // Ripple chain over the currently selected digit.
   always_comb begin
      base    = 32'(dig_q) * CHUNK;
      a_dig   = CHUNK'(a_q >> base);
      b_dig   = CHUNK'(b_q >> base);
      s_dig   = '0;
      chain_c = carry_q;
      for (int i = 0; i < int'(CHUNK); i++) begin
         s_dig[i] = a_dig[i] ^ b_dig[i] ^ chain_c;
         chain_c  = (a_dig[i] & b_dig[i]) | (chain_c & (a_dig[i] ^ b_dig[i]));
      end
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
      c_msb = s_dig[CHUNK-1] ^ a_dig[CHUNK-1] ^ b_dig[CHUNK-1];
`endif
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dig_d   = dig_q;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub ? 1'b1 : cin;
               dig_d   = '0;
               busy_d  = 1'b1;
               state_d = StRun;
            end else begin
               busy_d  = 1'b0;
               state_d = StIdle;
            end
         end
         StRun: begin
            sum_d   = (sum_q & ~(DigMask << base)) | (WIDTH'(s_dig) << base);
            carry_d = chain_c;
            if (dig_q == DW'(NDIG - 1)) begin
               cout_d  = chain_c;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
               ovf_d   = c_msb ^ chain_c;
`endif
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = StDone;
            end else begin
               dig_d = dig_q + DW'(1);
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dig_q   <= '0;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dig_q   <= dig_d;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: four WIDTH=8 instances (CHUNK = 2, 1, 4, 8) against an
// arithmetic reference model; ovf checks are built when DIGIT_SERIAL_ADDER_OVF_EN is defined.
module tb_digit_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] start_v = '0;
   logic       sub_i = 1'b0;
   logic       cin_i = 1'b0;
   logic [7:0] a_i = '0;
   logic [7:0] b_i = '0;
   logic [3:0] busy_v, done_v, cout_v;
   logic [7:0] sum_v [4];
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
   logic [3:0] ovf_v;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      digit_serial_adder #(
         .WIDTH(8),
         .CHUNK((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 8)
      ) u_dut (
         .clk  (clk),
         .rst_n(rst_n),
         .start(start_v[g]),
         .sub  (sub_i),
         .a    (a_i),
         .b    (b_i),
         .cin  (cin_i),
         .busy (busy_v[g]),
         .done (done_v[g]),
         .sum  (sum_v[g]),
         .cout (cout_v[g])
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        ,.ovf  (ovf_v[g])
`endif
      );
   end

   function automatic int ndig_of(input int k);
      case (k)
         0: return 4;
         1: return 8;
         2: return 2;
         default: return 1;
      endcase
   endfunction

   // Reference: plain integer arithmetic, signed overflow from the true signed result.
   function automatic void model(input logic sub, input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, output logic [7:0] s, output logic co,
                                 output logic ov);
      int ua = int'(a);
      int ub = int'(b);
      int sa = int'($signed(a));
      int sb = int'($signed(b));
      int r, sr;
      if (sub) begin
         r  = ua - ub;
         co = (ua >= ub);
         sr = sa - sb;
      end else begin
         r  = ua + ub + int'(cin);
         co = (r > 255);
         sr = sa + sb + int'(cin);
      end
      s  = r[7:0];
      ov = (sr > 127) || (sr < -128);
   endfunction

   task automatic run_op(input int k, input logic sub, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, output logic [7:0] s, output logic co,
                         output logic ov, output int lat, output int bcnt);
      @(negedge clk);
      sub_i = sub; a_i = a; b_i = b; cin_i = cin;
      start_v[k] = 1'b1;
      @(negedge clk);
      start_v[k] = 1'b0;
      a_i = 8'($urandom); b_i = 8'($urandom); sub_i = ~sub; cin_i = ~cin;
      lat = 1;
      bcnt = 0;
      while (done_v[k] !== 1'b1 && lat < 40) begin
         if (busy_v[k] === 1'b1) bcnt++;
         @(negedge clk);
         lat++;
      end
      s  = sum_v[k];
      co = cout_v[k];
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
      ov = ovf_v[k];
`else
      ov = 1'b0;
`endif
   endtask

   task automatic test_reset();
      #2;
      for (int k = 0; k < 4; k++) begin
         tests_run += 4;
         if (busy_v[k] !== 1'b0) begin
            tests_failed++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy_v[k]);
         end
         if (done_v[k] !== 1'b0) begin
            tests_failed++; $display("FAIL reset_done[%0d]: got %b expected 0", k, done_v[k]);
         end
         if (sum_v[k] !== 8'h00) begin
            tests_failed++; $display("FAIL reset_sum[%0d]: got %h expected 00", k, sum_v[k]);
         end
         if (cout_v[k] !== 1'b0) begin
            tests_failed++; $display("FAIL reset_cout[%0d]: got %b expected 0", k, cout_v[k]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [7:0] va [5] = '{8'h0F, 8'hFF, 8'h00, 8'h05, 8'h07};
      logic [7:0] vb [5] = '{8'h01, 8'h01, 8'h00, 8'h07, 8'h05};
      logic       vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic       vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [7:0] s, es;
      logic       co, eco, ov, eov;
      int         lat, bcnt;
      for (int i = 0; i < 5; i++) begin
         model(vs[i], va[i], vb[i], vc[i], es, eco, eov);
         run_op(0, vs[i], va[i], vb[i], vc[i], s, co, ov, lat, bcnt);
         tests_run += 5;
         if (s !== es) begin
            tests_failed++; $display("FAIL dir_sum[%0d]: got %h expected %h", i, s, es);
         end
         if (co !== eco) begin
            tests_failed++; $display("FAIL dir_cout[%0d]: got %b expected %b", i, co, eco);
         end
         if (lat != 5) begin
            tests_failed++; $display("FAIL dir_latency[%0d]: got %0d expected 5", i, lat);
         end
         if (bcnt != 4) begin
            tests_failed++; $display("FAIL dir_busy_cycles[%0d]: got %0d expected 4", i, bcnt);
         end
         if (busy_v[0] !== 1'b0) begin
            tests_failed++; $display("FAIL dir_busy_at_done[%0d]: got %b expected 0", i, busy_v[0]);
         end
      end
   endtask

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
   task automatic test_ovf();
      logic [7:0] va [3] = '{8'h7F, 8'h80, 8'h10};
      logic [7:0] vb [3] = '{8'h01, 8'h01, 8'h20};
      logic       vs [3] = '{1'b0, 1'b1, 1'b0};
      logic [7:0] s, es;
      logic       co, eco, ov, eov;
      int         lat, bcnt;
      for (int i = 0; i < 3; i++) begin
         model(vs[i], va[i], vb[i], 1'b0, es, eco, eov);
         run_op(0, vs[i], va[i], vb[i], 1'b0, s, co, ov, lat, bcnt);
         tests_run += 2;
         if (s !== es) begin
            tests_failed++; $display("FAIL ovf_sum[%0d]: got %h expected %h", i, s, es);
         end
         if (ov !== eov) begin
            tests_failed++; $display("FAIL ovf_flag[%0d]: got %b expected %b", i, ov, eov);
         end
      end
   endtask
`endif

   task automatic test_start_ignored();
      int lat;
      @(negedge clk);
      a_i = 8'h12; b_i = 8'h34; sub_i = 1'b0; cin_i = 1'b0; start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      lat = 1;
      @(negedge clk);
      lat++;
      a_i = 8'hAA; b_i = 8'h55; sub_i = 1'b1; start_v[0] = 1'b1;
      @(negedge clk);
      lat++;
      start_v[0] = 1'b0;
      while (done_v[0] !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      tests_run += 3;
      if (sum_v[0] !== 8'h46) begin
         tests_failed++; $display("FAIL ignore_sum: got %h expected 46", sum_v[0]);
      end
      if (cout_v[0] !== 1'b0) begin
         tests_failed++; $display("FAIL ignore_cout: got %b expected 0", cout_v[0]);
      end
      if (lat != 5) begin
         tests_failed++; $display("FAIL ignore_latency: got %0d expected 5", lat);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      @(negedge clk);
      a_i = 8'h3C; b_i = 8'h0A; sub_i = 1'b0; cin_i = 1'b0; start_v[0] = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (done_v[0] !== 1'b1 && lat < 40);
      tests_run += 2;
      if (sum_v[0] !== 8'h46) begin
         tests_failed++; $display("FAIL b2b_first_sum: got %h expected 46", sum_v[0]);
      end
      if (lat != 5) begin
         tests_failed++; $display("FAIL b2b_first_latency: got %0d expected 5", lat);
      end
      // start still high in the DONE cycle; new operands are taken at this edge.
      a_i = 8'hF0; b_i = 8'h20; sub_i = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      tests_run++;
      if (busy_v[0] !== 1'b1) begin
         tests_failed++; $display("FAIL b2b_no_idle: busy got %b expected 1", busy_v[0]);
      end
      lat = 1;
      while (done_v[0] !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      tests_run += 3;
      if (lat != 5) begin
         tests_failed++; $display("FAIL b2b_second_latency: got %0d expected 5", lat);
      end
      if (sum_v[0] !== 8'hD0) begin
         tests_failed++; $display("FAIL b2b_second_sum: got %h expected d0", sum_v[0]);
      end
      if (cout_v[0] !== 1'b1) begin
         tests_failed++; $display("FAIL b2b_second_cout: got %b expected 1", cout_v[0]);
      end
   endtask

   task automatic test_reset_mid();
      int         seen;
      logic [7:0] s;
      logic       co, ov;
      int         lat, bcnt;
      @(negedge clk);
      a_i = 8'h55; b_i = 8'h22; sub_i = 1'b0; cin_i = 1'b0; start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests_run += 4;
      if (busy_v[0] !== 1'b0) begin
         tests_failed++; $display("FAIL midrst_busy: got %b expected 0", busy_v[0]);
      end
      if (done_v[0] !== 1'b0) begin
         tests_failed++; $display("FAIL midrst_done: got %b expected 0", done_v[0]);
      end
      if (sum_v[0] !== 8'h00) begin
         tests_failed++; $display("FAIL midrst_sum: got %h expected 00", sum_v[0]);
      end
      if (cout_v[0] !== 1'b0) begin
         tests_failed++; $display("FAIL midrst_cout: got %b expected 0", cout_v[0]);
      end
      seen = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done_v[0] === 1'b1) seen++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done_v[0] === 1'b1) seen++;
      end
      tests_run++;
      if (seen != 0) begin
         tests_failed++; $display("FAIL midrst_no_done: got %0d pulses expected 0", seen);
      end
      run_op(0, 1'b0, 8'h33, 8'h11, 1'b0, s, co, ov, lat, bcnt);
      tests_run++;
      if (s !== 8'h44) begin
         tests_failed++; $display("FAIL midrst_after_sum: got %h expected 44", s);
      end
   endtask

   task automatic test_sweep();
      logic [7:0] s, es, ra, rb;
      logic       co, eco, ov, eov, rs, rc;
      int         lat, bcnt;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 25; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rs = 1'($urandom); rc = 1'($urandom);
            if (i == 0) begin ra = 8'hFF; rb = 8'hFF; rs = 1'b0; rc = 1'b1; end
            if (i == 1) begin ra = 8'h00; rb = 8'hFF; rs = 1'b1; end
            model(rs, ra, rb, rc, es, eco, eov);
            run_op(k, rs, ra, rb, rc, s, co, ov, lat, bcnt);
            tests_run += 3;
            if (s !== es) begin
               tests_failed++;
               $display("FAIL sweep_sum[k%0d,%0d]: a=%h b=%h sub=%b cin=%b got %h expected %h",
                        k, i, ra, rb, rs, rc, s, es);
            end
            if (co !== eco) begin
               tests_failed++;
               $display("FAIL sweep_cout[k%0d,%0d]: got %b expected %b", k, i, co, eco);
            end
            if (lat != ndig_of(k) + 1) begin
               tests_failed++;
               $display("FAIL sweep_latency[k%0d,%0d]: got %0d expected %0d", k, i, lat,
                        ndig_of(k) + 1);
            end
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
            tests_run++;
            if (ov !== eov) begin
               tests_failed++;
               $display("FAIL sweep_ovf[k%0d,%0d]: got %b expected %b", k, i, ov, eov);
            end
`endif
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
      test_ovf();
`endif
      test_start_ignored();
      test_back_to_back();
      test_reset_mid();
      test_sweep();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor; generalises the team's 4-bit ripple-carry adder to WIDTH bits.
- Each cycle it processes one CHUNK-bit digit through a CHUNK-stage ripple full-adder chain and registers the carry between digits.
- Trades latency for a short carry chain in area- and timing-constrained datapaths.
- Start/busy/done handshake to a controlling FSM.

Parameters:
- WIDTH, 16, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits processed per cycle (ripple-chain length); 1 <= CHUNK <= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request operation; accepted only when busy=0
- sub  input  1  0 = a+b+cin; 1 = a-b (sampled with start)
- a  input  WIDTH  operand A (sampled with start)
- b  input  WIDTH  operand B (sampled with start)
- cin  input  1  carry-in for add; ignored when sub=1
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when sum/cout are valid
- sum  output  WIDTH  result, held until the next accepted start
- cout  output  1  carry-out (add) / no-borrow (sub)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, sum=0, cout=0; internal operand, carry and digit-counter registers cleared. Reset mid-operation aborts immediately with no done pulse.
- NDIG = WIDTH/CHUNK; digit counter width = clog2(NDIG), minimum 1.
- FSM states:
  - IDLE: start=1 -> latch a; latch b if sub=0 or ~b if sub=1; carry <= sub ? 1 : cin; digit <= 0; go to RUN; busy=1 from the next cycle.
  - RUN: each cycle, ripple-add digit[digit] of A, B and carry; write the result into sum bits [digit*CHUNK +: CHUNK]; carry <= chain carry-out. If digit == NDIG-1, go to DONE and cout <= final carry; otherwise digit <= digit+1. start is ignored in RUN.
  - DONE: done=1 and busy=0 for exactly one cycle. start=1 here is accepted (back-to-back: latch and go to RUN); otherwise go to IDLE.
- Latency: start accepted at edge 0; RUN spans edges 1..NDIG; done is high in the cycle after edge NDIG.
- Throughput: one result per NDIG+1 cycles.
- sum is updated digit by digit during RUN; the final value is valid when done=1 and is held through IDLE until the next accepted start.
- Arithmetic is modulo 2^WIDTH. sub=1 yields two's-complement a-b; cout=1 means a >= b (unsigned).
- Operand and control inputs are sampled only at acceptance; changes during RUN have no effect.
- CHUNK == WIDTH is legal: single RUN cycle, done two cycles after the start edge.

Optional Feature:
- Macro: DIGIT_SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit) = signed overflow = carry into the MSB XOR carry out of the MSB.
  - Registered together with cout at the final digit; reset value 0; held with sum.
- Undefined: no ovf port and no MSB carry-in register.

Test Plan:
- WIDTH=8, CHUNK=2: a=0x0F, b=0x01, cin=0, sub=0 -> busy high for 4 cycles; done at cycle 5; sum=0x10, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0; sub=1, a=0x07, b=0x05, cin=1 -> sum=0x02, cout=1 (cin ignored).
- OVF_EN defined: a=0x7F, b=0x01 add -> sum=0x80, ovf=1; a=0x80, b=0x01 sub -> sum=0x7F, ovf=1; a=0x10, b=0x20 add -> ovf=0.
- start pulsed with new operands during RUN -> ignored, original result returned. start held during DONE -> second operation begins with no idle cycle, and done pulses again NDIG+1 cycles later.
- rst_n low at RUN cycle 2 -> busy, done, sum, cout read 0 immediately; no done pulse. After release, a=0x33, b=0x11 -> sum=0x44.
- Sweep CHUNK=1, 4 and 8 with WIDTH=8 over random operands vs a behavioural model -> exact match of sum, cout and latency.
